// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller.
// Holds the forwarding-select encoding and the multi-cycle stall FSM state encoding.
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mc_state_e;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Single-source forwarding comparator; purely combinational, no flow control.
// M stage beats W stage, and x0 is never forwarded.
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5
) (
  input  logic              regwrite_m,
  input  logic              regwrite_w,
  input  logic [REG_AW-1:0] rd_m,
  input  logic [REG_AW-1:0] rd_w,
  input  logic [REG_AW-1:0] rs,
  output logic [1:0]        sel
);

  always_comb begin
    sel = FWD_RF;
    if (regwrite_m && (rd_m != '0) && (rd_m == rs)) begin
      sel = FWD_MEM;
    end else if (regwrite_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard control: forwarding selects, load-use stall, branch flush, mul/div stall with watchdog.
// All stall/flush/forward outputs are combinational from current inputs and state; counters update on clk.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_SRC    = 2,
  parameter int REG_AW     = 5,
  parameter int CNT_W      = 32,
  parameter int MC_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic [REG_AW-1:0]         RD_M,
  input  logic [REG_AW-1:0]         RD_W,
  input  logic [NUM_SRC*REG_AW-1:0] RS_E,
  input  logic [REG_AW-1:0]         RS1_D,
  input  logic [REG_AW-1:0]         RS2_D,
  input  logic [REG_AW-1:0]         RD_E,
  input  logic                      LoadE,
  input  logic                      PCSrcE,
  input  logic                      mc_start_E,
  input  logic                      mc_done,
  output logic [NUM_SRC*2-1:0]      ForwardE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushM,
  output logic                      mc_timeout_err,
  output logic [CNT_W-1:0]          stall_cnt,
  output logic [CNT_W-1:0]          flush_cnt
);

  localparam int WD_W = $clog2(MC_TIMEOUT + 1);

  mc_state_e           state_q, state_nxt;
  logic [WD_W-1:0]     wd_cnt;
  logic [NUM_SRC*2-1:0] fwd_raw;
  logic                lw_stall;
  logic                stall_f, stall_d, stall_e;
  logic                flush_d, flush_e, flush_m;
  logic                timeout_hit;

  for (genvar i = 0; i < NUM_SRC; i++) begin : g_fwd
    fwd_sel #(.REG_AW(REG_AW)) u_fwd_sel (
      .regwrite_m (RegWriteM),
      .regwrite_w (RegWriteW),
      .rd_m       (RD_M),
      .rd_w       (RD_W),
      .rs         (RS_E[i*REG_AW +: REG_AW]),
      .sel        (fwd_raw[i*2 +: 2])
    );
  end

  assign lw_stall = LoadE && (RD_E != '0) && ((RD_E == RS1_D) || (RD_E == RS2_D)) && !PCSrcE;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // The start cycle already counts as cycle 1, so it stalls before the state reaches BUSY.
  always_comb begin
    state_nxt   = state_q;
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_m     = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      IDLE: begin
        if (mc_start_E && !mc_done) begin
          state_nxt = BUSY;
          stall_f   = 1'b1;
          stall_d   = 1'b1;
          stall_e   = 1'b1;
          flush_m   = 1'b1;
        end else begin
          stall_f = lw_stall;
          stall_d = lw_stall;
          flush_e = lw_stall || PCSrcE;
          flush_d = PCSrcE;
        end
      end
      BUSY: begin
        if (mc_done) begin
          state_nxt = IDLE;
        end else if (wd_cnt == WD_W'(MC_TIMEOUT)) begin
          state_nxt   = IDLE;
          timeout_hit = 1'b1;
        end else begin
          stall_f = 1'b1;
          stall_d = 1'b1;
          stall_e = 1'b1;
          flush_m = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_cnt         <= '0;
      mc_timeout_err <= 1'b0;
    end else begin
      if (state_q == IDLE && state_nxt == BUSY) begin
        wd_cnt <= WD_W'(2);
      end else if (state_q == BUSY && state_nxt == BUSY) begin
        wd_cnt <= wd_cnt + WD_W'(1);
      end else begin
        wd_cnt <= '0;
      end
      if (timeout_hit) begin
        mc_timeout_err <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
      if (state_q == IDLE && PCSrcE && (flush_cnt != '1)) begin
        flush_cnt <= flush_cnt + CNT_W'(1);
      end
    end
  end

  assign ForwardE = rst ? fwd_raw : '0;
  assign StallF   = rst & stall_f;
  assign StallD   = rst & stall_d;
  assign StallE   = rst & stall_e;
  assign FlushD   = rst & flush_d;
  assign FlushE   = rst & flush_e;
  assign FlushM   = rst & flush_m;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl built with CNT_W=4 and MC_TIMEOUT=8.
// Inputs change on the falling edge; combinational outputs are sampled 1 time unit later.
module tb_hazard_ctrl;

  localparam int NUM_SRC    = 2;
  localparam int REG_AW     = 5;
  localparam int CNT_W      = 4;
  localparam int MC_TIMEOUT = 8;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      RegWriteM, RegWriteW;
  logic [REG_AW-1:0]         RD_M, RD_W, RS1_D, RS2_D, RD_E;
  logic [NUM_SRC*REG_AW-1:0] RS_E;
  logic                      LoadE, PCSrcE, mc_start_E, mc_done;
  logic [NUM_SRC*2-1:0]      ForwardE;
  logic                      StallF, StallD, StallE, FlushD, FlushE, FlushM;
  logic                      mc_timeout_err;
  logic [CNT_W-1:0]          stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(
    .NUM_SRC(NUM_SRC), .REG_AW(REG_AW), .CNT_W(CNT_W), .MC_TIMEOUT(MC_TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .RD_M(RD_M), .RD_W(RD_W), .RS_E(RS_E),
    .RS1_D(RS1_D), .RS2_D(RS2_D), .RD_E(RD_E),
    .LoadE(LoadE), .PCSrcE(PCSrcE),
    .mc_start_E(mc_start_E), .mc_done(mc_done),
    .ForwardE(ForwardE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE),
    .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
    .mc_timeout_err(mc_timeout_err),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    RegWriteM = 0; RegWriteW = 0; RD_M = 0; RD_W = 0; RS_E = '0;
    RS1_D = 0; RS2_D = 0; RD_E = 0; LoadE = 0; PCSrcE = 0;
    mc_start_E = 0; mc_done = 0;
  endtask

  task automatic next_cycle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b0;
    // Reset forces everything to zero even with active forwarding/branch inputs
    RegWriteM = 1; RD_M = 5; RS_E = {5'd5, 5'd5}; PCSrcE = 1;
    #2;
    chk("rst_fwd", 32'(ForwardE), 32'h0);
    chk("rst_flushd", 32'(FlushD), 32'h0);
    chk("rst_stallcnt", 32'(stall_cnt), 32'h0);
    chk("rst_err", 32'(mc_timeout_err), 32'h0);
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;

    // Forwarding
    RS_E = {5'd5, 5'd5}; RD_M = 5; RegWriteM = 1; RD_W = 5; RegWriteW = 1;
    #1 chk("fwd_m_beats_w", 32'(ForwardE), 32'b1010);
    RD_M = 0;
    #1 chk("fwd_rdm_x0", 32'(ForwardE), 32'b0101);
    RS_E = {5'd3, 5'd5}; RD_M = 3; RD_W = 5;
    #1 chk("fwd_mixed", 32'(ForwardE), 32'b1001);
    RegWriteW = 0; RD_M = 0;
    #1 chk("fwd_none", 32'(ForwardE), 32'b0000);
    RS_E = '0; RD_W = 0; RegWriteW = 1; RegWriteM = 1;
    #1 chk("fwd_x0", 32'(ForwardE), 32'b0000);

    // Load-use
    @(negedge clk);
    clear_inputs();
    LoadE = 1; RD_E = 7; RS2_D = 7;
    #1;
    chk("lu_stallf", 32'(StallF), 32'h1);
    chk("lu_stalld", 32'(StallD), 32'h1);
    chk("lu_flushe", 32'(FlushE), 32'h1);
    chk("lu_flushd", 32'(FlushD), 32'h0);
    chk("lu_stalle", 32'(StallE), 32'h0);
    next_cycle();
    chk("lu_stallcnt", 32'(stall_cnt), 32'h1);
    PCSrcE = 1;
    #1;
    chk("br_stallf", 32'(StallF), 32'h0);
    chk("br_flushd", 32'(FlushD), 32'h1);
    chk("br_flushe", 32'(FlushE), 32'h1);
    next_cycle();
    chk("br_flushcnt", 32'(flush_cnt), 32'h1);
    chk("br_stallcnt", 32'(stall_cnt), 32'h1);
    clear_inputs();
    LoadE = 1; RD_E = 0; RS1_D = 0;
    #1 chk("lu_rd_x0", 32'(StallF), 32'h0);
    clear_inputs();

    // Start and done together: no stall
    mc_start_E = 1; mc_done = 1;
    #1 chk("mc_same_cycle", 32'(StallE), 32'h0);
    next_cycle();
    clear_inputs();
    chk("mc_same_after", 32'(StallF), 32'h0);

    // Multi-cycle op completing after 5 stall cycles
    mc_start_E = 1;
    #1 chk("mc_c1", 32'({StallF, StallD, StallE, FlushM}), 32'hF);
    for (int i = 2; i <= 5; i++) begin
      next_cycle();
      mc_start_E = 0;
      #1 chk($sformatf("mc_c%0d", i), 32'({StallF, StallD, StallE, FlushM}), 32'hF);
    end
    next_cycle();
    mc_done = 1;
    #1 chk("mc_done_cycle", 32'({StallF, StallD, StallE, FlushM}), 32'h0);
    next_cycle();
    mc_done = 0;
    chk("mc_stallcnt", 32'(stall_cnt), 32'h6);
    chk("mc_err", 32'(mc_timeout_err), 32'h0);
    chk("mc_idle", 32'(StallF), 32'h0);

    // Watchdog: mc_done never arrives
    mc_start_E = 1;
    #1 chk("wd_c1", 32'(StallF), 32'h1);
    for (int i = 2; i <= 7; i++) begin
      next_cycle();
      mc_start_E = 0;
      if (i == 4) begin
        LoadE = 1; RD_E = 9; RS1_D = 9; PCSrcE = 1;
      end else begin
        LoadE = 0; RD_E = 0; RS1_D = 0; PCSrcE = 0;
      end
      #1 chk($sformatf("wd_c%0d", i), 32'({StallF, StallE, FlushM}), 32'h7);
      if (i == 4) chk("wd_busy_flush", 32'({FlushD, FlushE}), 32'h0);
    end
    next_cycle();
    clear_inputs();
    #1 chk("wd_release", 32'({StallF, StallD, StallE, FlushM}), 32'h0);
    next_cycle();
    chk("wd_err", 32'(mc_timeout_err), 32'h1);
    chk("wd_stallcnt", 32'(stall_cnt), 32'hD);
    chk("wd_flushcnt", 32'(flush_cnt), 32'h1);
    repeat (20) @(negedge clk);
    #1;
    chk("wd_err_sticky", 32'(mc_timeout_err), 32'h1);
    chk("wd_idle_after", 32'(StallF), 32'h0);

    // Asynchronous reset while BUSY
    mc_start_E = 1;
    next_cycle();
    mc_start_E = 0;
    chk("ar_busy", 32'(StallF), 32'h1);
    #2;
    rst = 1'b0;
    PCSrcE = 1;
    #1;
    chk("ar_stalls", 32'({StallF, StallD, StallE, FlushM}), 32'h0);
    chk("ar_flushd", 32'(FlushD), 32'h0);
    chk("ar_err", 32'(mc_timeout_err), 32'h0);
    chk("ar_stallcnt", 32'(stall_cnt), 32'h0);
    @(negedge clk);
    clear_inputs();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      chk($sformatf("ar_idle%0d", i), 32'(StallF), 32'h0);
    end
    chk("ar_flushcnt", 32'(flush_cnt), 32'h0);

    // Saturation of stall_cnt
    LoadE = 1; RD_E = 7; RS1_D = 7;
    repeat (15) @(negedge clk);
    #1 chk("sat_reach", 32'(stall_cnt), 32'hF);
    repeat (5) @(negedge clk);
    #1 chk("sat_hold", 32'(stall_cnt), 32'hF);
    clear_inputs();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Next-generation pipeline hazard controller for the 5-stage RV32I core. It keeps the operand forwarding selection, generalised to NUM_SRC execute-stage sources. It adds load-use stall detection and taken-branch flush. It also adds a stall FSM for multi-cycle execute ops (mul/div) with a watchdog, plus saturating stall/flush performance counters. It sits beside the datapath and drives the F/D/E/M pipeline-register enables and flushes, and the E-stage operand muxes.

Parameters:
NUM_SRC, 2, number of E-stage source operands that need forwarding select
REG_AW, 5, register address width
CNT_W, 32, performance counter width
MC_TIMEOUT, 64, maximum BUSY cycles before the watchdog fires (must be >= 2)

Ports:
clk  in  1  core clock
rst  in  1  asynchronous active-low reset
RegWriteM  in  1  M-stage writes the register file
RegWriteW  in  1  W-stage writes the register file
RD_M  in  REG_AW  M-stage destination
RD_W  in  REG_AW  W-stage destination
RS_E  in  NUM_SRC*REG_AW  E-stage sources, source i at [i*REG_AW +: REG_AW]
RS1_D  in  REG_AW  D-stage source 1
RS2_D  in  REG_AW  D-stage source 2
RD_E  in  REG_AW  E-stage destination
LoadE  in  1  E-stage instruction is a load
PCSrcE  in  1  branch/jump taken, resolved in E
mc_start_E  in  1  multi-cycle op present in E (1-cycle pulse)
mc_done  in  1  multi-cycle unit result valid
ForwardE  out  NUM_SRC*2  per-source select: 00 regfile, 01 W, 10 M
StallF  out  1  hold PC
StallD  out  1  hold IF/ID
StallE  out  1  hold ID/EX
FlushD  out  1  clear IF/ID
FlushE  out  1  clear ID/EX
FlushM  out  1  insert bubble into EX/MEM
mc_timeout_err  out  1  sticky watchdog error
stall_cnt  out  CNT_W  cycles with StallF=1
flush_cnt  out  CNT_W  taken-branch flush events

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to IDLE; counters, watchdog and mc_timeout_err clear to 0.
  - All control outputs and ForwardE are forced to 0 combinationally while rst=0.
- Forwarding, combinational, independent per source i:
  - 10 if RegWriteM & RD_M!=0 & RD_M==RS_E[i].
  - Else 01 if RegWriteW & RD_W!=0 & RD_W==RS_E[i].
  - Else 00.
  - M beats W when both match. Register x0 is never forwarded.
- Load-use condition: lwStall = LoadE & RD_E!=0 & (RD_E==RS1_D | RD_E==RS2_D) & ~PCSrcE.
- FSM states are IDLE, BUSY.
- IDLE outputs:
  - StallF = StallD = lwStall.
  - FlushE = lwStall | PCSrcE.
  - FlushD = PCSrcE.
  - StallE = FlushM = 0.
- Taken branch beats load-use: with PCSrcE=1 there is no stall, only flush.
- IDLE->BUSY: mc_start_E=1 and mc_done=0. The start cycle itself already asserts the BUSY outputs combinationally. mc_start_E with mc_done=1 in the same cycle stays in IDLE with no stall.
- BUSY outputs: StallF = StallD = StallE = 1 and FlushM = 1. FlushD, FlushE and lwStall are suppressed.
- BUSY->IDLE: on mc_done=1. Stall deasserts in that same cycle, so the E result advances.
- Watchdog:
  - Counts BUSY cycles, starting from 1 on entry.
  - When the count reaches MC_TIMEOUT without mc_done: set mc_timeout_err, return to IDLE and release the stall.
  - mc_timeout_err stays set until reset. mc_done in the timeout cycle wins, with no error.
- mc_start_E while BUSY is ignored.
- Counters:
  - stall_cnt +1 on every cycle StallF=1.
  - flush_cnt +1 on every cycle PCSrcE=1 in IDLE.
  - Both saturate at all-ones and do not wrap.
- Latency: all stall and flush outputs are combinational from current inputs and state. Registered state updates on the clk rising edge.

Decomposition:
- hazard_pkg:
  - fwd_sel_e (FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10).
  - mc_state_e (IDLE, BUSY).
- One sub-module, fwd_sel: a single-source forwarding comparator, instantiated NUM_SRC times via generate.
- FSM, watchdog and counters are written inline.

Test Plan:
- RS_E={src1=5, src0=5}, RD_M=5, RegWriteM=1, RD_W=5, RegWriteW=1 -> ForwardE=4'b1010. Same stimulus with RD_M=0 -> 4'b0101.
- LoadE=1, RD_E=7, RS2_D=7 -> StallF=StallD=FlushE=1, FlushD=0, stall_cnt +1. Add PCSrcE=1 -> StallF=0, FlushD=FlushE=1, flush_cnt +1.
- mc_start_E pulse, mc_done after 5 cycles -> StallF/D/E=FlushM=1 for exactly 5 cycles, 0 in the mc_done cycle, stall_cnt=5, mc_timeout_err=0.
- mc_start_E with mc_done never asserted, MC_TIMEOUT=8 -> stall held 7 cycles, released in cycle 8, mc_timeout_err=1 and still 1 twenty cycles later.
- rst pulled low mid-BUSY -> all outputs 0 immediately (asynchronous). After release: IDLE, counters 0, no stall until a new mc_start_E.
- Force stall_cnt near saturation (CNT_W=4 build), hold lwStall for 20 cycles -> stall_cnt reaches 4'hF and stays there.
